// File: rtl/stream_addr_demux_reg.sv
// stream_addr_demux_reg
// ---------------------
// Registered address demultiplexer for a valid/ready beat stream. Each input
// beat (address + payload) is decoded against a priority-ordered rule table.
// The beat is then steered through a single-entry output register to one of
// NrOutput valid/ready outputs. Unmatched beats either go to DefaultSlave or,
// with DropUnmatched=1, are accepted and discarded. In both modes they raise
// a one-cycle dec_err_o pulse and bump a saturating error counter.
//
// Handshake semantics (all ports): a beat transfers on a rising clk edge when
// valid and ready are both high. Once valid is raised, the payload is held
// until the transfer happens. Ready may depend combinationally on the
// downstream ready, but valid never depends on ready.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   inp_valid_i/ready_o input beat handshake
//   inp_addr_i/data_i   input beat address / payload
//   oup_valid_o         one-hot output valid (bit oup_sel_o)
//   oup_ready_i         per-output ready; only the selected bit is observed
//   oup_addr_o/data_o   registered beat, shared by all outputs
//   oup_sel_o           index of the output currently driven
//   rule_en_i           per-rule enable
//   addr_mask_i         per-rule address mask
//   addr_base_i         per-rule address base
//   addr_slave_i        per-rule target output index
//   dec_err_o           pulse: an unmatched beat was accepted last cycle
//   err_cnt_o           saturating count of unmatched accepted beats
//   err_cnt_clr_i       synchronous counter clear (wins over increment)
module stream_addr_demux_reg #(
  parameter int unsigned NrOutput      = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NrRules       = 4,
  parameter int unsigned DefaultSlave  = 0,
  parameter bit          DropUnmatched = 1'b0,
  parameter int unsigned ErrCntWidth   = 8,
  // Derived; do not override.
  parameter int unsigned SelWidth      = (NrOutput > 1) ? $clog2(NrOutput) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               inp_valid_i,
  output logic                               inp_ready_o,
  input  logic [AddrWidth-1:0]               inp_addr_i,
  input  logic [DataWidth-1:0]               inp_data_i,
  output logic [NrOutput-1:0]                oup_valid_o,
  input  logic [NrOutput-1:0]                oup_ready_i,
  output logic [AddrWidth-1:0]               oup_addr_o,
  output logic [DataWidth-1:0]               oup_data_o,
  output logic [SelWidth-1:0]                oup_sel_o,
  input  logic [NrRules-1:0]                 rule_en_i,
  input  logic [NrRules-1:0][AddrWidth-1:0]  addr_mask_i,
  input  logic [NrRules-1:0][AddrWidth-1:0]  addr_base_i,
  input  logic [NrRules-1:0][SelWidth-1:0]   addr_slave_i,
  output logic                               dec_err_o,
  output logic [ErrCntWidth-1:0]             err_cnt_o,
  input  logic                               err_cnt_clr_i
);

  // Decode result for the beat currently presented on the input.
  logic                 dec_match;
  logic [SelWidth-1:0]  dec_sel;
  logic                 dec_drop;

  // Output register.
  logic                 full_q;
  logic [SelWidth-1:0]  sel_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;

  logic                 dec_err_q;
  logic [ErrCntWidth-1:0] err_cnt_q;

  logic handshake_out;
  logic accept;
  logic load;

  // Priority decode: the first matching rule claims the beat, so later rules
  // never merge in. Rules pointing at a non-existent output are ignored
  // rather than producing an out-of-range select.
  always_comb begin
    dec_match = 1'b0;
    dec_sel   = SelWidth'(DefaultSlave);
    for (int i = 0; i < int'(NrRules); i++) begin
      if (!dec_match && rule_en_i[i] &&
          ((inp_addr_i & addr_mask_i[i]) == (addr_base_i[i] & addr_mask_i[i])) &&
          (32'(addr_slave_i[i]) < NrOutput)) begin
        dec_match = 1'b1;
        dec_sel   = addr_slave_i[i];
      end
    end
  end

  assign dec_drop = DropUnmatched && !dec_match;

  // Only the ready of the selected output matters; the others may toggle
  // freely without disturbing the held beat.
  assign handshake_out = full_q & oup_ready_i[sel_q];

  // The register frees up in the same cycle it drains, so the input can
  // stream one beat per cycle as long as the selected output keeps up.
  assign inp_ready_o = !full_q | handshake_out;
  assign accept      = inp_valid_i & inp_ready_o;
  assign load        = accept & !dec_drop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (load) begin
        full_q <= 1'b1;
        sel_q  <= dec_sel;
        addr_q <= inp_addr_i;
        data_q <= inp_data_i;
      end else if (handshake_out) begin
        // Covers both "no accept" and "accepted a drop beat".
        full_q <= 1'b0;
      end
    end
  end

  // Error reporting: every accepted unmatched beat counts, whether it was
  // routed to the default output or dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      dec_err_q <= accept & !dec_match;
      if (err_cnt_clr_i) begin
        err_cnt_q <= '0;
      end else if (accept && !dec_match && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
      end
    end
  end

  always_comb begin
    oup_valid_o        = '0;
    oup_valid_o[sel_q] = full_q;
  end

  assign oup_sel_o  = sel_q;
  assign oup_addr_o = addr_q;
  assign oup_data_o = data_q;
  assign dec_err_o  = dec_err_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: doc/stream_addr_demux_reg.md
Name: stream_addr_demux_reg

Overview:
- Registered, payload-carrying successor to the combinational address demux.
- Decodes each input beat's address against a priority-ordered rule table, then steers the beat (address + data) through a one-entry output register to one of NrOutput valid/ready outputs.
- Unmatched beats go to a default output or are dropped, counted and flagged.
- Sits between a master port and its fabric crossbar legs, and breaks the combinational decode path.

Parameters:
- NrOutput, 4, number of output streams (>=2).
- AddrWidth, 32, address width.
- DataWidth, 32, payload width.
- NrRules, 4, number of routing rules (>=1).
- DefaultSlave, 0, output index for unmatched beats when DropUnmatched=0.
- DropUnmatched, 0, 1: consume and discard unmatched beats instead of routing them.
- ErrCntWidth, 8, width of the saturating decode-error counter.
- SelWidth, derived: max(1,$clog2(NrOutput)); not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- inp_valid_i  in  1  input beat valid.
- inp_ready_o  out  1  input beat ready.
- inp_addr_i  in  AddrWidth  beat address.
- inp_data_i  in  DataWidth  beat payload.
- oup_valid_o  out  NrOutput  one-hot output valid.
- oup_ready_i  in  NrOutput  output ready.
- oup_addr_o  out  AddrWidth  registered address, shared by all outputs.
- oup_data_o  out  DataWidth  registered payload, shared by all outputs.
- oup_sel_o  out  SelWidth  index of the output currently driven.
- rule_en_i  in  NrRules  per-rule enable.
- addr_mask_i  in  NrRules x AddrWidth  rule masks.
- addr_base_i  in  NrRules x AddrWidth  rule bases.
- addr_slave_i  in  NrRules x SelWidth  rule target index.
- dec_err_o  out  1  one-cycle pulse: an unmatched beat was accepted in the previous cycle.
- err_cnt_o  out  ErrCntWidth  saturating count of unmatched beats.
- err_cnt_clr_i  in  1  synchronous counter clear.

Behaviour:
- Reset (async assert, sync release): output register empty, oup_valid_o='0, oup_sel_o=0, oup_addr_o=0, oup_data_o=0, dec_err_o=0, err_cnt_o=0.
- Decode (combinational on the input side):
  - Rule i matches iff rule_en_i[i] and (inp_addr_i & addr_mask_i[i]) == (addr_base_i[i] & addr_mask_i[i]) and addr_slave_i[i] < NrOutput.
  - Lowest matching index wins; no OR-merging of targets.
  - Mask 0 on an enabled rule matches every address.
- No match:
  - DropUnmatched=0: target = DefaultSlave.
  - DropUnmatched=1: beat is a drop beat.
- Output register: single entry, flag full.
  - oup_valid_o[oup_sel_o] = full; all other bits are 0.
  - handshake_out = full & oup_ready_i[oup_sel_o]. Ready bits of unselected outputs are ignored.
- inp_ready_o = !full | handshake_out. Ready is combinationally dependent on oup_ready_i, which gives full throughput (one beat per cycle) with back-to-back beats to any mix of outputs.
- Accept (inp_valid_i & inp_ready_o):
  - Normal beat: register loads addr, data and sel; full=1 next cycle. Latency is exactly 1 cycle from input handshake to output valid.
  - Drop beat: accepted, not stored. full becomes 0 if handshake_out occurred, otherwise it is unchanged. Note that a drop beat needs inp_ready_o like any other beat.
- No accept and handshake_out: full=0.
- While full and not handshaken, oup_valid_o, oup_sel_o, oup_addr_o and oup_data_o are held stable.
- Rule-table changes never affect a beat already registered.
- Error path:
  - Every accepted unmatched beat (both modes) sets dec_err_o=1 for the following cycle.
  - The same event increments err_cnt_o, saturating at all-ones.
  - Clear and increment in the same cycle: clear wins, err_cnt_o=0.
  - Counter holds its value while saturated.
- Reset mid-operation: any held beat is discarded without a handshake; the counter resets to 0.
- No combinational path from inp_* to oup_*. The only combinational paths are the decode and oup_ready_i -> inp_ready_o.

Test Plan:
- Priority:
  - Setup: rule0 base 0x1000 mask 0xF000 -> slave 2; rule1 base 0x0000 mask 0x0000 -> slave 1; both enabled.
  - Stimulus: addr 0x1234.
  - Required: oup_valid_o=4'b0100 one cycle after accept, oup_addr_o=0x1234. Then addr 0x2000 -> 4'b0010.
- Backpressure:
  - Stimulus: beat to slave 2 with oup_ready_i[2]=0 for 5 cycles, oup_ready_i[3]=1, and a second beat waiting.
  - Required: inp_ready_o=0 and the output held stable for all 5 cycles. When oup_ready_i[2]=1, the second beat is accepted in the same cycle.
- Throughput:
  - Stimulus: 8 back-to-back beats alternating slaves 1 and 3, all ready=1.
  - Required: 8 output handshakes in 8 consecutive cycles, in order.
- Default and drop:
  - DropUnmatched=0, no rule enabled: addr 0x5 -> output DefaultSlave, dec_err_o pulse, err_cnt_o=1.
  - DropUnmatched=1, same beat: no oup_valid_o, inp_ready_o=1, err_cnt_o=1.
- Counter:
  - Stimulus: ErrCntWidth=2, 5 drop beats -> err_cnt_o=3 (saturated).
  - Stimulus: err_cnt_clr_i high together with a drop beat -> err_cnt_o=0.
- Reset:
  - Stimulus: assert rst_i while full and stalled.
  - Required: oup_valid_o drops to 0 asynchronously and err_cnt_o=0. After release, the next beat routes normally.
